// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert, synchronised and staggered per-channel release.
// Define RST_SEQ_SW_REQ_EN to enable masked software re-sequencing.
module rst_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_resetn,
  output logic              rst_done,
  output logic              busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam bit SINGLE = (NUM_CH == 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NUM_CH-1:0]      act;
  logic [NUM_CH-1:0]      slot;
  logic [NUM_CH-1:0]      slot0;

`ifdef RST_SEQ_SW_REQ_EN
  logic [NUM_CH-1:0] mask_q;
  assign act = mask_q;
`else
  wire unused_sw = sw_rst_req ^ (^ch_mask);
  assign act = '1;
`endif

  assign slot  = act & (NUM_CH'(1) << idx);
  assign slot0 = act & NUM_CH'(1);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state     <= S_WAIT;
      cnt       <= '0;
      idx       <= '0;
      ch_resetn <= '0;
      rst_done  <= 1'b0;
      busy      <= 1'b1;
`ifdef RST_SEQ_SW_REQ_EN
      mask_q    <= '1;
`endif
    end else begin
      unique case (state)
        S_WAIT: begin
          if (sync_q[SYNC_STAGES-1]) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            ch_resetn <= ch_resetn | slot0;
            cnt       <= '0;
            idx       <= IDX_W'(1);
            if (SINGLE) begin
              state    <= S_DONE;
              rst_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == STAG_LAST) begin
            ch_resetn <= ch_resetn | slot;
            cnt       <= '0;
            if (idx == LAST_IDX) begin
              state    <= S_DONE;
              rst_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
`ifdef RST_SEQ_SW_REQ_EN
          // Unmasked channels keep running; only masked ones re-sequence.
          if (sw_rst_req && (|ch_mask)) begin
            mask_q    <= ch_mask;
            ch_resetn <= ch_resetn & ~ch_mask;
            rst_done  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_HOLD;
            cnt       <= '0;
          end
`endif
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: timing tables, abort/glitch cases, random vs model.
// Honours RST_SEQ_SW_REQ_EN the same way the design does.
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int H  = 16;
  localparam int ST = 4;
`ifdef RST_SEQ_SW_REQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         sw   = 1'b0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] ch;
  logic         done;
  logic         busy;
  logic [0:0]   ch1;
  logic         done1;
  logic         busy1;
  logic         sw1   = 1'b0;
  logic [0:0]   mask1 = 1'b0;

  rst_seq_ctrl #(
    .NUM_CH(N), .SYNC_STAGES(S), .HOLD_CYCLES(H),
    .STAGGER(ST), .CNT_W(8)
  ) dut (
    .sys_clk(clk), .sys_resetn(rstn),
    .sw_rst_req(sw), .ch_mask(mask),
    .ch_resetn(ch), .rst_done(done), .busy(busy)
  );

  rst_seq_ctrl #(
    .NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1),
    .STAGGER(1), .CNT_W(8)
  ) dut1 (
    .sys_clk(clk), .sys_resetn(rstn),
    .sw_rst_req(sw1), .ch_mask(mask1),
    .ch_resetn(ch1), .rst_done(done1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int           ecnt   = 0;
  int           k_rel  = 0;
  int           t0     = 0;
  logic [N-1:0] smask  = '1;
  bit           in_rst = 1'b1;
  int           errs   = 0;
  int           checks = 0;

  typedef struct {
    int         off;
    logic       sw;
    logic [3:0] mask;
    logic [3:0] ch;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tab[8];
  int   tab_n;

  // Expected outputs from the release-time formulas of the current sequence
  function automatic logic [N-1:0] m_ch(int n);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      if (in_rst)         v[i] = 1'b0;
      else if (!smask[i]) v[i] = 1'b1;
      else                v[i] = (n >= t0 + H + i * ST);
    end
    return v;
  endfunction

  function automatic logic m_done(int n);
    return !in_rst && (n >= t0 + H + (N - 1) * ST);
  endfunction

  function automatic logic m_small(int n);
    return !in_rst && (n >= k_rel + 5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, ecnt, a, e);
    end
  endtask

  task automatic check_all();
    chk("ch_resetn", ch, m_ch(ecnt));
    chk("rst_done", done, m_done(ecnt));
    chk("busy", busy, !m_done(ecnt));
    chk("ch1_resetn", ch1, m_small(ecnt));
    chk("ch1_done", done1, m_small(ecnt));
    chk("ch1_busy", busy1, !m_small(ecnt));
  endtask

  task automatic step();
    @(posedge clk);
    ecnt++;
    if (SW_EN && !in_rst && sw && (mask != '0) && m_done(ecnt - 1)) begin
      t0    = ecnt;
      smask = mask;
    end
    #1;
    check_all();
  endtask

  task automatic release_rst();
    rstn   = 1'b1;
    in_rst = 1'b0;
    k_rel  = ecnt;
    t0     = ecnt + S + 1;
    smask  = '1;
  endtask

  task automatic pulse_rst(input int low_ns);
    #2;
    rstn   = 1'b0;
    in_rst = 1'b1;
    #1;
    check_all();
    #(low_ns);
    release_rst();
  endtask

  task automatic run_tab(input int base, input int max_off, input string nm);
    for (int r = 0; r < tab_n; r++) begin
      if (tab[r].off <= max_off) begin
        sw   = tab[r].sw;
        mask = tab[r].mask;
        while (ecnt - base < tab[r].off) step();
        chk({nm, "_ch"}, ch, tab[r].ch);
        chk({nm, "_done"}, done, tab[r].done);
        chk({nm, "_busy"}, busy, tab[r].busy);
      end
    end
  endtask

  task automatic fill_rel();
    tab[0] = '{1,  1'b0, 4'h0, 4'b0000, 1'b0, 1'b1};
    tab[1] = '{18, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b1};
    tab[2] = '{19, 1'b0, 4'h0, 4'b0001, 1'b0, 1'b1};
    tab[3] = '{22, 1'b0, 4'h0, 4'b0001, 1'b0, 1'b1};
    tab[4] = '{23, 1'b0, 4'h0, 4'b0011, 1'b0, 1'b1};
    tab[5] = '{27, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b1};
    tab[6] = '{30, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b1};
    tab[7] = '{31, 1'b0, 4'h0, 4'b1111, 1'b1, 1'b0};
    tab_n  = 8;
  endtask

  task automatic fill_sw();
    if (SW_EN) begin
      tab[0] = '{0,  1'b1, 4'b1010, 4'b0101, 1'b0, 1'b1};
      tab[1] = '{10, 1'b1, 4'b1111, 4'b0101, 1'b0, 1'b1};
      tab[2] = '{19, 1'b1, 4'b1111, 4'b0101, 1'b0, 1'b1};
      tab[3] = '{20, 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b1};
      tab[4] = '{24, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1};
      tab[5] = '{27, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1};
      tab[6] = '{28, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};
    end else begin
      tab[0] = '{0,  1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0};
      tab[1] = '{10, 1'b1, 4'b1010, 4'b1111, 1'b1, 1'b0};
      tab[2] = '{19, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0};
      tab[3] = '{20, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0};
      tab[4] = '{24, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};
      tab[5] = '{27, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};
      tab[6] = '{28, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};
    end
    tab_n = 7;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step();
    #2;
    release_rst();
    fill_rel();
    run_tab(k_rel, 100, "rel");

    // Abort in the middle of the stagger phase, then a full rerun
    pulse_rst(2);
    run_tab(k_rel, 23, "rel2");
    while (ecnt - k_rel < 25) step();
    pulse_rst(2);
    chk("abort_ch", ch, 4'b0000);
    chk("abort_done", done, 1'b0);
    run_tab(k_rel, 100, "rel3");

    fill_sw();
    run_tab(ecnt + 1, 100, "sw");
    sw   = 1'b1;
    mask = '0;
    for (int i = 0; i < 6; i++) step();
    chk("mask0_ch", ch, 4'b1111);
    chk("mask0_done", done, 1'b1);
    sw = 1'b0;

    // Glitch shorter than a cycle
    pulse_rst(1);
    while (ecnt - k_rel < 31) step();

    for (int c = 0; c < 3000; c++) begin
      sw   = ($urandom_range(0, 5) == 0);
      mask = N'($urandom);
      step();
      if ($urandom_range(0, 299) == 0) pulse_rst($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised, synthesizable reset sequencer for multi-domain IP subsystems such as timers and their bus interfaces. It takes the chip-level asynchronous active-low reset and asserts every channel reset asynchronously. Deassertion is synchronised, then held for a programmable settle time, then channels are released one at a time in index order with a fixed stagger. A software reset request re-runs the sequence on a selected subset of channels without touching the others.

## Interface
- NUM_CH, 4, number of reset channels (≥1)
- SYNC_STAGES, 2, flops in the deassertion synchroniser (≥2)
- HOLD_CYCLES, 16, cycles held after synchronised deassertion before channel 0 is released (≥1)
- STAGGER, 4, cycles between successive channel releases (≥1)
- CNT_W, 8, counter width; HOLD_CYCLES and STAGGER must be ≤ 2^CNT_W

- sys_clk  in  1  single clock; all logic on rising edge
- sys_resetn  in  1  reset, asynchronous, active-low
- sw_rst_req  in  1  synchronous software reset request, sampled per edge
- ch_mask  in  NUM_CH  channels affected by sw_rst_req, bit i → channel i
- ch_resetn  out  NUM_CH  per-channel active-low resets
- rst_done  out  1  high when all channels are released and the sequence is idle
- busy  out  1  high while a sequence is in progress

## Operation
- FSM states: WAIT, HOLD, RELEASE, DONE. Counter cnt is CNT_W bits. Channel index idx is clog2(NUM_CH) bits, minimum 1.
- sys_resetn low: immediately and asynchronously, state←WAIT, cnt←0, idx←0, synchroniser←0, ch_resetn←0, rst_done←0, busy←1. This applies in every state, including mid-sequence.
- WAIT: when the synchroniser output is 1, state←HOLD and cnt←0.
- HOLD: if cnt==HOLD_CYCLES-1, release the first active channel slot (channel 0), set cnt←0 and idx←1, and go to RELEASE (or DONE if NUM_CH==1). Otherwise cnt++.
- RELEASE: if cnt==STAGGER-1, release slot idx and set cnt←0. If idx==NUM_CH-1, go to DONE; otherwise idx++. Otherwise cnt++.
- Releasing a slot sets ch_resetn[i]←1 only if channel i is active. All channels are active after a sys_resetn sequence. After a software request, only the latched-mask channels are active.
- DONE: rst_done=1, busy=0. A sampled sw_rst_req=1 with ch_mask≠0 does the following on that edge:
  - latches ch_mask;
  - drives ch_resetn[i]←0 for each mask bit set;
  - sets rst_done←0, busy←1, state←HOLD, cnt←0.
- Unmasked channels stay 1 throughout the software sequence. Their slots still consume STAGGER time.
- sw_rst_req is ignored outside DONE: no queuing, no sticky latch. It is also ignored when ch_mask==0.
- ch_mask changes after the request edge have no effect until the next request.

## Timing
- Reset values: ch_resetn=0, rst_done=0, busy=1.
- Assertion of all channel resets is combinationally asynchronous, through flop async clear.
- Deassertion, with edge 1 being the first rising edge after sys_resetn rises:
  - synchroniser output is high after edge SYNC_STAGES;
  - WAIT→HOLD on edge SYNC_STAGES+1;
  - ch_resetn[i] rises on edge SYNC_STAGES+1+HOLD_CYCLES+i·STAGGER;
  - rst_done rises and busy falls on the same edge as ch_resetn[NUM_CH-1].
- Software request accepted on edge e:
  - masked channels fall on edge e;
  - channel i (if masked) rises on edge e+HOLD_CYCLES+i·STAGGER;
  - rst_done rises on edge e+HOLD_CYCLES+(NUM_CH-1)·STAGGER.
- sys_resetn falling during WAIT, HOLD, RELEASE or a software sequence aborts it. The full sequence restarts from WAIT.
- sys_resetn glitch shorter than one cycle: outputs still clear asynchronously, and the full sequence runs again.
- All outputs are registered and glitch-free.

## Configuration
- Macro RST_SEQ_SW_REQ_EN.
- Defined: the software request path is present as described above.
- Undefined: sw_rst_req and ch_mask ports remain but are ignored, and no mask register is synthesised. DONE is terminal until sys_resetn is asserted. Only sys_resetn can start a sequence.

## Test plan
- Defaults, release sys_resetn between edges → ch_resetn bits rise at edges 19, 23, 27, 31; rst_done=1 and busy=0 at edge 31; all outputs 0/0/1 before release.
- sys_resetn pulsed low at edge 25 (mid-RELEASE) → ch_resetn immediately 4'b0000 and rst_done=0. After release the full 19/23/27/31 sequence repeats.
- In DONE (RST_SEQ_SW_REQ_EN defined), sw_rst_req=1 with ch_mask=4'b1010 at edge e → ch_resetn=4'b0101 at e. Channel 1 rises at e+20, channel 3 at e+28. Channels 0 and 2 never drop. rst_done returns at e+28.
- sw_rst_req held high during RELEASE, and with ch_mask=0 in DONE → no change to ch_resetn, state or rst_done.
- Parameters NUM_CH=1, HOLD_CYCLES=1, STAGGER=1, SYNC_STAGES=3 → ch_resetn[0] and rst_done rise together at edge 5.
- RST_SEQ_SW_REQ_EN undefined, sw_rst_req=1 with ch_mask=4'b1111 in DONE → outputs unchanged (4'b1111, rst_done=1).
